// File: rtl/muldiv_unit_if.sv
// Handshake and data bundle between the EX stage and the iterative RV32M multiply/divide unit.
// master = pipeline side (launches ops), slave = the unit itself.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            Start;
    logic            Flush;
    logic [2:0]      Funct_3;
    logic [XLEN-1:0] Op_A;
    logic [XLEN-1:0] Op_B;
    logic            Busy;
    logic            Done;
    logic [XLEN-1:0] Result;

    modport master (
        output Start, Flush, Funct_3, Op_A, Op_B,
        input  Busy, Done, Result
    );

    modport slave (
        input  Start, Flush, Funct_3, Op_A, Op_B,
        output Busy, Done, Result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU unit, one op per Start pulse.
// Latency: fixed XLEN+3 cycles from accept to Done (PREP, XLEN x CALC, FIX, then DONE pulse).
// Backpressure: none queued; Start is ignored while Busy, Flush aborts without a Done.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] result_q;
    logic            neg_a_q;
    logic            neg_b_q;
    logic [CW-1:0]   cnt_q;

    logic            accept;
    logic            is_div;
    logic            sgn_a;
    logic            sgn_b;
    logic            neg_a_w;
    logic            neg_b_w;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_trial;
    logic [XLEN:0]   div_diff;
    logic            q_bit;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] fix_val;

    assign accept = bus.Start && !bus.Flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_PREP;
            S_PREP:  state_nxt = S_CALC;
            S_CALC:  if (cnt_q == '0) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (bus.Flush) state_nxt = S_IDLE;
    end

    always_comb begin
        bus.Busy   = (state != S_IDLE);
        bus.Done   = (state == S_DONE) && !bus.Flush;
        bus.Result = result_q;
    end

    // MULHSU treats only rs1 as signed; MUL's low word is sign-agnostic so it runs unsigned.
    assign is_div  = op_q[2];
    assign sgn_a   = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
    assign sgn_b   = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
    assign neg_a_w = sgn_a && a_q[XLEN-1];
    assign neg_b_w = sgn_b && b_q[XLEN-1];
    assign mag_a   = neg_a_w ? (~a_q + 1'b1) : a_q;
    assign mag_b   = neg_b_w ? (~b_q + 1'b1) : b_q;

    // hi:lo doubles as product register (multiply) and remainder:dividend/quotient (divide).
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    assign div_trial = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = div_trial - {1'b0, b_q};
    assign q_bit     = div_trial[XLEN] || !div_diff[XLEN];

    assign prod     = {hi_q, lo_q};
    assign prod_fix = (neg_a_q ^ neg_b_q) ? (~prod + 1'b1) : prod;

    always_comb begin
        quo_fix = (neg_a_q ^ neg_b_q) ? (~lo_q + 1'b1) : lo_q;
        rem_fix = neg_a_q ? (~hi_q + 1'b1) : hi_q;
        // A zero divisor still runs the full iteration; the architectural result is forced here.
        if (b_q == '0) begin
            quo_fix = '1;
            rem_fix = a_q;
        end
    end

    always_comb begin
        fix_val = '0;
        case (op_q)
            3'b000:                 fix_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = quo_fix;
            default:                fix_val = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q <= bus.Funct_3;
                        a_q  <= bus.Op_A;
                        b_q  <= bus.Op_B;
                    end
                end
                S_PREP: begin
                    neg_a_q <= neg_a_w;
                    neg_b_q <= neg_b_w;
                    b_q     <= mag_b;
                    hi_q    <= '0;
                    lo_q    <= mag_a;
                    cnt_q   <= CW'(XLEN - 1);
                end
                S_CALC: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (is_div) begin
                        hi_q <= q_bit ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
                        lo_q <= {lo_q[XLEN-2:0], q_bit};
                    end else begin
                        hi_q <= mul_sum[XLEN:1];
                        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                end
                S_FIX: begin
                    if (!bus.Flush) result_q <= fix_val;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M corner vectors plus random ops against an arithmetic model,
// and the Start-while-busy, Flush, mid-op reset and back-to-back scenarios.
module tb_muldiv_unit;
    localparam int XLEN = 32;
    localparam int LAT  = 35;

    localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
    localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();
    muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = '0;
        case (f)
            F_MUL:    p = ua * ub;
            F_MULH:   p = (sa * sb) >>> 32;
            F_MULHSU: p = (sa * ub) >>> 32;
            F_MULHU:  p = (ua * ub) >> 32;
            F_DIV: begin
                if (b == 32'd0) p = '1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, a};
                else p = sa / sb;
            end
            F_DIVU:   p = (b == 32'd0) ? 64'hFFFF_FFFF : ua / ub;
            F_REM: begin
                if (b == 32'd0) p = {32'd0, a};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = '0;
                else p = sa % sb;
            end
            default:  p = (b == 32'd0) ? {32'd0, a} : ua % ub;
        endcase
        return p[31:0];
    endfunction

    // Launches one op and waits (bounded) for Done; returns the result and accept-to-Done cycles.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output logic busy1);
        @(negedge clk);
        bus.Start = 1'b1; bus.Funct_3 = f; bus.Op_A = a; bus.Op_B = b;
        @(negedge clk);
        bus.Start = 1'b0; bus.Op_A = $urandom; bus.Op_B = $urandom; bus.Funct_3 = 3'($urandom);
        lat   = 1;
        busy1 = bus.Busy;
        while (bus.Done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = bus.Result;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.Start = 1'b1; bus.Flush = 1'b0; bus.Funct_3 = F_MUL; bus.Op_A = 32'd3; bus.Op_B = 32'd4;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.Busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", bus.Busy); failures++; end
        checks++;
        if (bus.Done !== 1'b0) begin $display("FAIL reset_done got=%b exp=0", bus.Done); failures++; end
        checks++;
        if (bus.Result !== 32'd0) begin $display("FAIL reset_result got=%h exp=0", bus.Result); failures++; end
        bus.Start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.Busy !== 1'b0) begin $display("FAIL reset_idle_busy got=%b exp=0", bus.Busy); failures++; end
    endtask

    task automatic test_directed();
        vec_t v[15];
        logic [31:0] res;
        int lat;
        logic b1;
        v[0]  = '{F_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        v[1]  = '{F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        v[2]  = '{F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        v[3]  = '{F_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
        v[4]  = '{F_DIVU,   32'd100,       32'd7,         32'd14};
        v[5]  = '{F_REMU,   32'd100,       32'd7,         32'd2};
        v[6]  = '{F_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        v[7]  = '{F_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        v[8]  = '{F_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF};
        v[9]  = '{F_REMU,   32'd5,         32'd0,         32'd5};
        v[10] = '{F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        v[11] = '{F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        v[12] = '{F_DIV,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF};
        v[13] = '{F_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
        v[14] = '{F_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF};
        for (int i = 0; i < 15; i++) begin
            run_op(v[i].f, v[i].a, v[i].b, res, lat, b1);
            checks++;
            if (res !== v[i].e) begin
                $display("FAIL directed_%0d f=%0d a=%h b=%h got=%h exp=%h", i, v[i].f, v[i].a, v[i].b, res, v[i].e);
                failures++;
            end
            checks++;
            if (lat !== LAT) begin $display("FAIL directed_lat_%0d got=%0d exp=%0d", i, lat, LAT); failures++; end
            checks++;
            if (b1 !== 1'b1) begin $display("FAIL directed_busy_%0d got=%b exp=1", i, b1); failures++; end
        end
    endtask

    task automatic test_random();
        logic [31:0] corner[6];
        logic [31:0] a, b, res, exp;
        logic [2:0]  f;
        int lat;
        logic b1;
        corner = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd3};
        for (int i = 0; i < 48; i++) begin
            f = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 30);
            exp = ref_model(f, a, b);
            run_op(f, a, b, res, lat, b1);
            checks++;
            if (res !== exp || lat !== LAT) begin
                $display("FAIL random_%0d f=%0d a=%h b=%h got=%h exp=%h lat=%0d exp_lat=%0d", i, f, a, b, res, exp, lat, LAT);
                failures++;
            end
        end
    endtask

    task automatic test_start_ignored();
        int c, dones, first;
        logic [31:0] res;
        @(negedge clk);
        bus.Start = 1'b1; bus.Funct_3 = F_MUL; bus.Op_A = 32'd7; bus.Op_B = 32'd9;
        @(negedge clk);
        c = 1; dones = 0; first = 0; res = '0;
        while (c < 80) begin
            bus.Start   = (c == 10);
            bus.Funct_3 = F_DIVU; bus.Op_A = 32'd1000; bus.Op_B = 32'd3;
            @(negedge clk);
            c++;
            if (bus.Done === 1'b1) begin
                dones++;
                if (first == 0) begin first = c; res = bus.Result; end
            end
        end
        bus.Start = 1'b0;
        checks++;
        if (dones !== 1) begin $display("FAIL ignore_done_count got=%0d exp=1", dones); failures++; end
        checks++;
        if (first !== LAT) begin $display("FAIL ignore_latency got=%0d exp=%0d", first, LAT); failures++; end
        checks++;
        if (res !== 32'd63) begin $display("FAIL ignore_result got=%h exp=%h", res, 32'd63); failures++; end
    endtask

    // Aborts a running op at cycle 20 with either Flush (use_rst=0) or a reset pulse (use_rst=1).
    task automatic test_abort(input logic use_rst);
        logic [31:0] res, keep;
        int lat, dones;
        logic b1;
        run_op(F_MUL, 32'd6, 32'd7, res, lat, b1);
        checks++;
        if (res !== 32'd42) begin $display("FAIL abort_pre_result rst=%b got=%h exp=%h", use_rst, res, 32'd42); failures++; end
        keep = use_rst ? 32'd0 : 32'd42;
        @(negedge clk);
        bus.Start = 1'b1; bus.Funct_3 = F_DIVU; bus.Op_A = 32'd1000; bus.Op_B = 32'd10;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (19) @(negedge clk);
        if (use_rst) rst = 1'b1; else bus.Flush = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.Flush = 1'b0;
        checks++;
        if (bus.Busy !== 1'b0) begin $display("FAIL abort_busy rst=%b got=%b exp=0", use_rst, bus.Busy); failures++; end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.Done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin $display("FAIL abort_no_done rst=%b got=%0d exp=0", use_rst, dones); failures++; end
        checks++;
        if (bus.Result !== keep) begin $display("FAIL abort_result rst=%b got=%h exp=%h", use_rst, bus.Result, keep); failures++; end
        bus.Start = 1'b1; bus.Flush = 1'b1; bus.Funct_3 = F_MUL; bus.Op_A = 32'd2; bus.Op_B = 32'd2;
        @(negedge clk);
        bus.Start = 1'b0; bus.Flush = 1'b0;
        checks++;
        if (bus.Busy !== 1'b0) begin $display("FAIL flush_beats_start got=%b exp=0", bus.Busy); failures++; end
        run_op(F_REMU, 32'd1000, 32'd7, res, lat, b1);
        checks++;
        if (res !== 32'd6 || lat !== LAT) begin
            $display("FAIL abort_after_op rst=%b got=%h exp=%h lat=%0d exp_lat=%0d", use_rst, res, 32'd6, lat, LAT);
            failures++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat;
        logic b1;
        logic [31:0] a[3];
        logic [31:0] b[3];
        logic [2:0]  f[3];
        f = '{F_MULHU, F_DIV, F_REM};
        a = '{32'h1234_5678, 32'hFFFF_FF00, 32'd77};
        b = '{32'h9ABC_DEF0, 32'd16, 32'hFFFF_FFF6};
        for (int i = 0; i < 3; i++) begin
            run_op(f[i], a[i], b[i], res, lat, b1);
            checks++;
            if (res !== ref_model(f[i], a[i], b[i]) || lat !== LAT) begin
                $display("FAIL b2b_%0d got=%h exp=%h lat=%0d exp_lat=%0d", i, res, ref_model(f[i], a[i], b[i]), lat, LAT);
                failures++;
            end
        end
        @(negedge clk);
        checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            $display("FAIL b2b_idle busy=%b done=%b exp=0/0", bus.Busy, bus.Done);
            failures++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.Start = 1'b0; bus.Flush = 1'b0; bus.Funct_3 = 3'd0; bus.Op_A = '0; bus.Op_B = '0;
        test_reset();
        test_directed();
        test_start_ignored();
        test_abort(1'b0);
        test_abort(1'b1);
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
